frv_mpa_unit: RTL and testbench

Multi-precision arithmetic unit for the XCrypto `xc.madd.3`, `xc.msub.3` and `xc.mmul.3` instructions. It sits in the execute stage, between operand dispatch and writeback. It takes three 32-bit source operands and returns a 64-bit result split into `out_lo` and `out_hi`. Writeback places these in the even/odd destination register pair, which is the pair the formal instruction model checks as `rd_wdata` / `rd_wdatahi`. Add and subtract take one cycle; multiply is an iterative 32-cycle shift-add.

---
 rtl/frv_mpa_unit.sv | 150 +++++++++++++++
 tb/tb_frv_mpa_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mpa_unit.sv
`default_nettype none
// ============================================================================
// Module   : frv_mpa_unit
// Function : XCrypto multi-precision add/sub (1 cycle) and iterative
//            32-cycle shift-add multiply-accumulate, 64-bit result.
// Revision : 1.0 - initial release
// ============================================================================
module frv_mpa_unit (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_rs3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_lo,
    output logic [31:0] out_hi
);

    localparam logic [1:0] c_OP_MADD = 2'b00;
    localparam logic [1:0] c_OP_MSUB = 2'b01;
    localparam logic [1:0] c_OP_MMUL = 2'b10;
    localparam logic [4:0] c_CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_mplier;
    logic [31:0] r_mcand;
    logic [31:0] r_out_lo;
    logic [31:0] r_out_hi;

    logic        w_accept;
    logic        w_mul_last;
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic [63:0] w_result;
    logic [63:0] w_partial;
    logic [63:0] w_acc_next;

    // Single-cycle ops: bit 32 of the 33-bit sum/difference is the carry/borrow.
    assign w_add = {1'b0, in_rs1} + {1'b0, in_rs2} + {32'b0, in_rs3[0]};
    assign w_sub = {1'b0, in_rs1} - {1'b0, in_rs2} - {32'b0, in_rs3[0]};

    always_comb begin
        w_result = 64'd0;
        case (in_op)
            c_OP_MADD: w_result = {31'b0, w_add};
            c_OP_MSUB: w_result = {31'b0, w_sub};
            default:   w_result = 64'd0;
        endcase
    end

    assign w_partial  = r_mplier[r_cnt] ? ({32'b0, r_mcand} << r_cnt) : 64'd0;
    assign w_acc_next = r_acc + w_partial;
    assign w_mul_last = (r_cnt == c_CNT_LAST);
    assign w_accept   = (r_state == ST_IDLE) && in_valid && !flush;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush takes priority over accept and over the result handshake.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = (in_op == c_OP_MMUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_mplier <= 32'd0;
            r_mcand  <= 32'd0;
            r_out_lo <= 32'd0;
            r_out_hi <= 32'd0;
        end else if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_op == c_OP_MMUL) begin
                            r_acc    <= {32'b0, in_rs3};
                            r_cnt    <= 5'd0;
                            r_mplier <= in_rs1;
                            r_mcand  <= in_rs2;
                        end else begin
                            r_out_lo <= w_result[31:0];
                            r_out_hi <= w_result[63:32];
                        end
                    end
                end
                ST_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_mul_last) begin
                        r_out_lo <= w_acc_next[31:0];
                        r_out_hi <= w_acc_next[63:32];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_lo = r_out_lo;
    assign out_hi = r_out_hi;

endmodule
`default_nettype wire

// File: tb/tb_frv_mpa_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_mpa_unit
// Function : Directed self-checking bench for frv_mpa_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_mpa_unit;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_rs3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_lo;
    logic [31:0] out_hi;

    int checks   = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    frv_mpa_unit dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rs3    (in_rs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lo    (out_lo),
        .out_hi    (out_hi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rs3   = c;
        in_valid = 1'b1;
        @(negedge g_clk);
        in_valid = 1'b0;
    endtask

    // lat counts cycles from acceptance: 1 is the cycle right after the accept edge.
    task automatic wait_result(output int lat, output logic rdy_seen);
        lat      = 1;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge g_clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge g_clk);
    endtask

    initial begin
        int   lat;
        logic rdy;
        logic ok;

        g_resetn  = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = 2'b00;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        in_rs3    = 32'd0;
        repeat (2) @(negedge g_clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_lo", out_lo, 32'd0);
        chk("reset_out_hi", out_hi, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        g_resetn = 1'b1;
        @(negedge g_clk);

        issue(2'b00, 32'hFFFF_FFFF, 32'd1, 32'd1);
        chk("madd_carry_valid", 32'(out_valid), 32'd1);
        chk("madd_carry_lo", out_lo, 32'h0000_0001);
        chk("madd_carry_hi", out_hi, 32'h0000_0001);
        release_result();

        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'd1);
        chk("reserved_valid", 32'(out_valid), 32'd1);
        chk("reserved_lo", out_lo, 32'd0);
        chk("reserved_hi", out_hi, 32'd0);
        release_result();

        issue(2'b00, 32'd2, 32'd3, 32'd0);
        chk("madd_small_lo", out_lo, 32'd5);
        chk("madd_small_hi", out_hi, 32'd0);
        release_result();
        chk("idle_after_handshake", 32'(in_ready), 32'd1);

        issue(2'b01, 32'd5, 32'd7, 32'd1);
        chk("msub_borrow_valid", 32'(out_valid), 32'd1);
        chk("msub_borrow_lo", out_lo, 32'hFFFF_FFFD);
        chk("msub_borrow_hi", out_hi, 32'd1);
        release_result();

        issue(2'b01, 32'd5, 32'd7, 32'hFFFF_FFFE);
        chk("msub_rs3bit0_lo", out_lo, 32'hFFFF_FFFE);
        chk("msub_rs3bit0_hi", out_hi, 32'd1);
        release_result();

        issue(2'b01, 32'd10, 32'd3, 32'd1);
        chk("msub_noborrow_lo", out_lo, 32'd6);
        chk("msub_noborrow_hi", out_hi, 32'd0);
        release_result();

        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, rdy);
        chk("mmul_max_latency", 32'(lat), 32'd33);
        chk("mmul_max_in_ready_low", 32'(rdy), 32'd0);
        chk("mmul_max_lo", out_lo, 32'h0000_0000);
        chk("mmul_max_hi", out_hi, 32'hFFFF_FFFF);
        release_result();

        issue(2'b10, 32'h0001_0000, 32'h0001_0000, 32'd0);
        wait_result(lat, rdy);
        chk("mmul_pow2_lo", out_lo, 32'd0);
        chk("mmul_pow2_hi", out_hi, 32'd1);
        release_result();

        out_ready = 1'b0;
        issue(2'b10, 32'd3, 32'd4, 32'd5);
        wait_result(lat, rdy);
        chk("bp_latency", 32'(lat), 32'd33);
        chk("bp_lo", out_lo, 32'd17);
        chk("bp_hi", out_hi, 32'd0);
        in_op    = 2'b00;
        in_rs1   = 32'd1;
        in_rs2   = 32'd1;
        in_rs3   = 32'd1;
        in_valid = 1'b1;
        ok       = 1'b1;
        repeat (10) begin
            @(negedge g_clk);
            if (out_valid !== 1'b1 || out_lo !== 32'd17 || out_hi !== 32'd0 || in_ready !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_hold_stable", 32'(ok), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge g_clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        repeat (10) @(negedge g_clk);
        flush = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        ok = 1'b1;
        repeat (40) begin
            @(negedge g_clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("flush_no_result", 32'(ok), 32'd1);
        issue(2'b00, 32'd1, 32'd1, 32'd1);
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_lo", out_lo, 32'd3);
        release_result();

        in_op    = 2'b00;
        in_rs1   = 32'd9;
        in_rs2   = 32'd9;
        in_rs3   = 32'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge g_clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_out_valid", 32'(out_valid), 32'd0);
        chk("flush_accept_in_ready", 32'(in_ready), 32'd1);

        issue(2'b10, 32'd3, 32'd4, 32'd5);
        repeat (20) @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_lo", out_lo, 32'd0);
        chk("midreset_hi", out_hi, 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);

        issue(2'b10, 32'd1000, 32'd1000, 32'd7);
        wait_result(lat, rdy);
        chk("post_reset_latency", 32'(lat), 32'd33);
        chk("post_reset_lo", out_lo, 32'h000F_4247);
        chk("post_reset_hi", out_hi, 32'd0);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
